// File: rtl/cga_alu_sseq.sv
// Multi-cycle SMUX/Q-register sequencer for 16-bit MUL, DIV and SHIFT, one bit per clock.
// Optional macro CGA_ALU_SEQ_DIVFIX_EN adds a FIX cycle that restores a negative DIV remainder.
module cga_alu_sseq (
  input  logic       sysclk,
  input  logic       sys_rst_n,
  input  logic       START,
  input  logic [1:0] OP,
  input  logic [3:0] COUNT,
  input  logic       Q0,
  input  logic       SIGN,
  input  logic       HOLD,
  input  logic       ABORT,
  output logic       SA,
  output logic       SB,
  output logic       FSUB,
  output logic       LDQ,
  output logic       QSHIFT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [4:0] STEP
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_FIX, S_FIN} state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  state_t     r_state, w_next;
  logic [1:0] r_op;
  logic [3:0] r_cnt;
  logic [4:0] r_step;
  logic       r_err;
  logic [3:0] w_last_idx;
  logic       w_last_step;
  logic       w_fix_req;
  logic       w_start_ok;
  logic       w_start_bad;
  logic [1:0] w_sel;

  // COUNT of 0 wraps to a last index of 15, i.e. 16 steps
  assign w_last_idx  = (r_op == OP_SHIFT) ? (r_cnt - 4'd1) : 4'd15;
  assign w_last_step = (r_step == {1'b0, w_last_idx});

`ifdef CGA_ALU_SEQ_DIVFIX_EN
  assign w_fix_req = (r_op == OP_DIV) && SIGN;
`else
  assign w_fix_req = 1'b0;
`endif

  assign w_start_ok  = (r_state == S_IDLE) && START && !ABORT && (OP != OP_ILL);
  assign w_start_bad = (r_state == S_IDLE) && START && !ABORT && (OP == OP_ILL);

  always_comb begin
    w_next = r_state;
    if (ABORT) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start_ok) w_next = S_INIT;
        S_INIT:  if (!HOLD) w_next = S_RUN;
        S_RUN:   if (!HOLD && w_last_step) w_next = w_fix_req ? S_FIX : S_FIN;
        S_FIX:   if (!HOLD) w_next = S_FIN;
        S_FIN:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_MUL;
      r_cnt   <= 4'd0;
      r_step  <= 5'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_start_bad;
      if (w_start_ok) begin
        r_op   <= OP;
        r_cnt  <= COUNT;
        r_step <= 5'd0;
      end else if (ABORT) begin
        r_step <= 5'd0;
      end else if (r_state == S_RUN && !HOLD) begin
        r_step <= r_step + 5'd1;
      end
    end
  end

  // Q0 and SIGN feed the selects combinationally so the ALU sees this step's decision
  always_comb begin
    w_sel  = 2'b11;
    FSUB   = 1'b0;
    LDQ    = 1'b0;
    QSHIFT = 1'b0;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    case (r_state)
      S_INIT: begin
        w_sel = 2'b00;
        BUSY  = 1'b1;
        LDQ   = !HOLD;
      end
      S_RUN: begin
        BUSY   = 1'b1;
        QSHIFT = !HOLD;
        case (r_op)
          OP_MUL: w_sel = Q0 ? 2'b01 : 2'b10;
          OP_DIV: begin
            w_sel = 2'b01;
            FSUB  = (r_step == 5'd0) ? 1'b1 : !SIGN;
          end
          default: w_sel = 2'b00;
        endcase
      end
      S_FIX: begin
        w_sel = 2'b01;
        BUSY  = 1'b1;
      end
      S_FIN:   DONE = 1'b1;
      default: w_sel = 2'b11;
    endcase
  end

  assign SA   = w_sel[0];
  assign SB   = w_sel[1];
  assign ERR  = r_err;
  assign STEP = r_step;

endmodule

// File: tb/tb_cga_alu_sseq.sv
// Directed bench for cga_alu_sseq: MUL/DIV/SHIFT sequencing, HOLD, ABORT, ERR and async reset.
module tb_cga_alu_sseq;

  logic       sysclk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       START = 1'b0;
  logic [1:0] OP = 2'b00;
  logic [3:0] COUNT = 4'd0;
  logic       Q0 = 1'b0;
  logic       SIGN = 1'b0;
  logic       HOLD = 1'b0;
  logic       ABORT = 1'b0;
  logic       SA, SB, FSUB, LDQ, QSHIFT, BUSY, DONE, ERR;
  logic [4:0] STEP;

  int n_chk = 0;
  int n_bad = 0;

`ifdef CGA_ALU_SEQ_DIVFIX_EN
  localparam bit FIX_EN = 1'b1;
`else
  localparam bit FIX_EN = 1'b0;
`endif

  cga_alu_sseq dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .START(START), .OP(OP), .COUNT(COUNT),
    .Q0(Q0), .SIGN(SIGN), .HOLD(HOLD), .ABORT(ABORT),
    .SA(SA), .SB(SB), .FSUB(FSUB), .LDQ(LDQ), .QSHIFT(QSHIFT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .STEP(STEP)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packed as {SB,SA,FSUB,LDQ,QSHIFT,BUSY,DONE,ERR,STEP}
  task automatic expect_out(input string tag, input logic [1:0] sel, input logic fsub,
                            input logic ldq, input logic qsh, input logic busy,
                            input logic done, input logic err, input logic [4:0] step);
    chk(tag, {19'd0, SB, SA, FSUB, LDQ, QSHIFT, BUSY, DONE, ERR, STEP},
        {19'd0, sel, fsub, ldq, qsh, busy, done, err, step});
  endtask

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  // Issues one operation and checks every cycle; hold covers absolute cycles [hold_cyc, hold_cyc+hold_n)
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] cnt,
                        input int nsteps, input int hold_cyc, input int hold_n,
                        input logic last_sign);
    int cyc_no;
    int s;
    bit held;
    bit do_fix;
    logic [1:0] esel;
    logic efsub;
    logic [31:0] sv;
    OP = op; COUNT = cnt; START = 1'b1;
    cyc();
    START = 1'b0;
    expect_out({tag, "_init"}, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    cyc();
    cyc_no = 2;
    s = 0;
    while (s < nsteps) begin
      sv = s;
      Q0   = ~sv[0];
      SIGN = (s == nsteps - 1) ? last_sign : sv[1];
      held = (cyc_no >= hold_cyc) && (cyc_no < hold_cyc + hold_n);
      HOLD = held;
      #1;
      case (op)
        2'b00:   begin esel = Q0 ? 2'b01 : 2'b10; efsub = 1'b0; end
        2'b01:   begin esel = 2'b01; efsub = (s == 0) ? 1'b1 : ~SIGN; end
        default: begin esel = 2'b00; efsub = 1'b0; end
      endcase
      expect_out($sformatf("%s_run_c%0d", tag, cyc_no), esel, efsub, 1'b0, ~held,
                 1'b1, 1'b0, 1'b0, s[4:0]);
      @(posedge sysclk);
      #1;
      if (!held) s++;
      cyc_no++;
    end
    HOLD = 1'b0;
    SIGN = 1'b0;
    do_fix = FIX_EN && (op == 2'b01) && last_sign;
    if (do_fix) begin
      expect_out({tag, "_fix"}, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'(nsteps));
      cyc();
    end
    expect_out({tag, "_done"}, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'(nsteps));
    cyc();
    chk({tag, "_post"}, {30'd0, BUSY, DONE}, 32'd0);
  endtask

  initial begin
    #3;
    expect_out("reset", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    #9 sys_rst_n = 1'b1;
    cyc();
    expect_out("idle", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    // MUL: DONE at cycle 18
    run_op("mul", 2'b00, 4'd0, 16, 0, 0, 1'b0);
    // DIV ending with SIGN=1: FIX at 18 and DONE at 19 only with the fix option
    run_op("div_s1", 2'b01, 4'd0, 16, 0, 0, 1'b1);
    run_op("div_s0", 2'b01, 4'd0, 16, 0, 0, 1'b0);
    // SHIFT 3: DONE at cycle 5; COUNT 0 means 16 steps, DONE at 18
    run_op("shf3", 2'b10, 4'd3, 3, 0, 0, 1'b0);
    run_op("shf0", 2'b10, 4'd0, 16, 0, 0, 1'b0);
    run_op("shf1", 2'b10, 4'd1, 1, 0, 0, 1'b0);
    // MUL with HOLD on cycles 5 and 6: DONE slips to cycle 20
    run_op("mul_hold", 2'b00, 4'd0, 16, 5, 2, 1'b0);

    // ABORT during step 7
    OP = 2'b00; START = 1'b1;
    cyc();
    START = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("abort_pre_step", {27'd0, STEP}, 32'd7);
    ABORT = 1'b1;
    cyc();
    ABORT = 1'b0;
    chk("abort_idle", {28'd0, SB, SA, BUSY, DONE}, 32'b1100);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("abort_nodone", {30'd0, BUSY, DONE}, 32'd0);
    end

    // Illegal OP: one-cycle ERR, never busy
    OP = 2'b11; START = 1'b1;
    cyc();
    START = 1'b0;
    chk("err_pulse", {30'd0, ERR, BUSY}, 32'b10);
    cyc();
    chk("err_clear", {29'd0, ERR, BUSY, LDQ}, 32'd0);

    // Async reset during DIV step 9
    OP = 2'b01; START = 1'b1;
    cyc();
    START = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("rst_pre_step", {27'd0, STEP}, 32'd9);
    sys_rst_n = 1'b0;
    #1;
    expect_out("rst_async", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    #2 sys_rst_n = 1'b1;
    cyc();
    expect_out("rst_idle", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    run_op("mul_after_rst", 2'b00, 4'd0, 16, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
